jogo_sequenciador: RTL and testbench
====================================

JOGO_SEQUENCIADOR -- requirements
Module: jogo_sequenciador

Interface
REQ-001 Parameter META_PONTOS, default 10, SHALL be the score (pontuacao) that ends a match as a win.
REQ-002 Parameter MAX_RODADAS, default 20, SHALL be the round limit that ends a match.
REQ-003 Parameter LFSR_SEED, default 8'hA5, non-zero, SHALL be the target-generator reset value.
REQ-004 clock  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 iniciar  in  1  start/restart request, sampled in OCIOSO and FIM only.
REQ-007 pausar  in  1  pause toggle, sampled in JOGANDO and PAUSA only.
REQ-008 nivel_sel  in  2  difficulty requested, latched on start.
REQ-009 ganhou_ponto / perdeu_ponto  in  1 each  round-end indications from the game datapath.
REQ-010 pontuacao  in  8  current unsigned score from the game datapath.
REQ-011 conta_nivel  out  1  enables the datapath round counter.
REQ-012 reset_ponto / reset_nivel  out  1 each  synchronous clears for the score and round counters.
REQ-013 position_led  out  4  current target LED index.
REQ-014 nivel_dificuldade  out  2  latched difficulty.
REQ-015 rodada  out  8  rounds started in the current match.
REQ-016 fim_jogo / venceu  out  1 each  match over; match won.
REQ-017 estado  out  3  state code for debug.

Function
REQ-018 The FSM SHALL have these states: OCIOSO=0, PREPARA=1, NOVA_RODADA=2, JOGANDO=3, PAUSA=4, AVALIA=5, FIM=6; codes 7 SHALL go to OCIOSO.
REQ-019 In OCIOSO with iniciar=1, the block SHALL latch nivel_sel into nivel_dificuldade, clear rodada to 0 and go to PREPARA.
REQ-020 PREPARA SHALL last 1 cycle with reset_ponto=1 and reset_nivel=1, then go to NOVA_RODADA.
REQ-021 NOVA_RODADA SHALL last 1 cycle and do all of the following:
  - reset_nivel=1;
  - shift the LFSR once;
  - load position_led;
  - increment rodada (saturating at 255);
  - go to JOGANDO.
REQ-022 The LFSR SHALL be 8-bit Fibonacci with polynomial x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0.
REQ-023 New target SHALL be the post-shift lfsr[3:0]; if it equals the current position_led, it SHALL be that value +1 mod 16 instead.
REQ-024 In JOGANDO, conta_nivel SHALL be 1, and exits SHALL follow this priority:
  - ganhou_ponto=1 or perdeu_ponto=1 -> AVALIA;
  - else pausar=1 -> PAUSA;
  - else stay.
REQ-025 Simultaneous ganhou_ponto and perdeu_ponto SHALL be treated as a single round end (one transition to AVALIA).
REQ-026 In PAUSA, conta_nivel SHALL be 0; pausar=1 -> JOGANDO; ganhou_ponto/perdeu_ponto SHALL be ignored.
REQ-027 AVALIA SHALL last 1 cycle with conta_nivel=0 and sample pontuacao there (one cycle after the round end, so the score update is visible):
  - pontuacao >= META_PONTOS -> FIM, venceu set to 1;
  - else rodada >= MAX_RODADAS -> FIM, venceu set to 0;
  - else -> NOVA_RODADA.
REQ-028 In FIM, fim_jogo SHALL be 1 and venceu SHALL hold; iniciar=1 -> PREPARA with a new nivel_sel latch, rodada=0, venceu=0.
REQ-029 Outputs SHALL be strobed only in these states:
  - conta_nivel: JOGANDO only;
  - reset_ponto: PREPARA only;
  - reset_nivel: PREPARA and NOVA_RODADA only.
REQ-030 The LFSR SHALL NOT advance outside NOVA_RODADA; position_led SHALL hold between rounds and across FIM.
REQ-031 Latency SHALL be 3 cycles from iniciar in OCIOSO to the first conta_nivel=1 (PREPARA, NOVA_RODADA, JOGANDO).
REQ-032 Latency SHALL be 3 cycles from a round end (when not finished) to conta_nivel=1 again (AVALIA, NOVA_RODADA, JOGANDO).
REQ-033 iniciar SHALL be ignored in all states other than OCIOSO and FIM.

Reset
REQ-034 reset=1 SHALL force, on the next edge and from any state including mid-round or PAUSA:
  - estado=OCIOSO;
  - LFSR=LFSR_SEED;
  - position_led=0, nivel_dificuldade=0, rodada=0;
  - fim_jogo=0, venceu=0;
  - conta_nivel, reset_ponto and reset_nivel all 0.
REQ-035 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-036 After reset, iniciar=1 for 1 cycle with nivel_sel=2 -> estado 1,2,3 on successive cycles; reset_ponto pulse of 1 cycle; reset_nivel high 2 cycles; nivel_dificuldade=2; rodada=1; position_led=lfsr[3:0] after one shift of 8'hA5 (0x4A -> 4'hA).
REQ-037 In JOGANDO, pausar pulse -> conta_nivel=0; ganhou_ponto pulse while paused -> no transition; second pausar pulse -> conta_nivel=1.
REQ-038 With META_PONTOS=2, drive ganhou_ponto twice with pontuacao stepping 1 then 2 one cycle later -> second AVALIA goes to FIM; fim_jogo=1, venceu=1, rodada=2.
REQ-039 With MAX_RODADAS=3 and only perdeu_ponto (pontuacao=0) -> FIM after the 3rd round end; venceu=0; rodada=3.
REQ-040 With ganhou_ponto and perdeu_ponto high in the same JOGANDO cycle -> exactly one AVALIA and rodada incremented once; force an LFSR nibble equal to the current target -> position_led = target+1 mod 16.
REQ-041 Assert reset in JOGANDO while conta_nivel=1 -> next cycle estado=0 and all outputs 0; a subsequent iniciar replays the REQ-036 sequence exactly.

Source files
------------

// File: rtl/jogo_sequenciador_if.sv
// Handshake/bus bundle between the game sequencer and the game datapath.
// slave: the sequencer side. master: the datapath or bench side.
interface jogo_sequenciador_if;
  // Requests and round-end indications flowing into the sequencer
  logic       iniciar;
  logic       pausar;
  logic [1:0] nivel_sel;
  logic       ganhou_ponto;
  logic       perdeu_ponto;
  logic [7:0] pontuacao;

  // Control strobes and status flowing out of the sequencer
  logic       conta_nivel;
  logic       reset_ponto;
  logic       reset_nivel;
  logic [3:0] position_led;
  logic [1:0] nivel_dificuldade;
  logic [7:0] rodada;
  logic       fim_jogo;
  logic       venceu;
  logic [2:0] estado;

  modport slave (
    input  iniciar, pausar, nivel_sel, ganhou_ponto, perdeu_ponto, pontuacao,
    output conta_nivel, reset_ponto, reset_nivel, position_led,
           nivel_dificuldade, rodada, fim_jogo, venceu, estado
  );

  modport master (
    output iniciar, pausar, nivel_sel, ganhou_ponto, perdeu_ponto, pontuacao,
    input  conta_nivel, reset_ponto, reset_nivel, position_led,
           nivel_dificuldade, rodada, fim_jogo, venceu, estado
  );
endinterface

// File: rtl/jogo_sequenciador.sv
// Match sequencer for the LED target game. It steps each match through
// prepare / new round / play / pause / evaluate / end, picks a new target LED
// every round from an 8-bit LFSR, and strobes the datapath counters.
// Every output is a register, so it lines up exactly with the state code.
module jogo_sequenciador #(
  parameter int unsigned META_PONTOS = 10,
  parameter int unsigned MAX_RODADAS = 20,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic               clock,
  input  logic               reset,
  jogo_sequenciador_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    PREPARA     = 3'd1,
    NOVA_RODADA = 3'd2,
    JOGANDO     = 3'd3,
    PAUSA       = 3'd4,
    AVALIA      = 3'd5,
    FIM         = 3'd6
  } estado_t;

  estado_t    st, st_nxt;
  logic [7:0] lfsr;
  logic [7:0] lfsr_shift;
  logic [3:0] alvo;
  logic [3:0] pos_q;
  logic [1:0] nivel_q;
  logic [7:0] rodada_q;
  logic       conta_q, rst_ponto_q, rst_nivel_q, fim_q, venceu_q;
  logic       round_end, start_req;
  logic       atingiu_meta, esgotou_rodadas;

  // Widen both sides to 32 bits so the parameter compares stay unsigned and lint-clean
  logic [31:0] pont_w, rodada_w;
  assign pont_w   = {24'd0, bus.pontuacao};
  assign rodada_w = {24'd0, rodada_q};

  assign atingiu_meta    = (pont_w >= META_PONTOS);
  assign esgotou_rodadas = (rodada_w >= MAX_RODADAS);

  // Simultaneous win/lose pulses merge into one round end
  assign round_end = bus.ganhou_ponto | bus.perdeu_ponto;
  // iniciar only matters while idle or after a finished match
  assign start_req = bus.iniciar & ((st == OCIOSO) | (st == FIM));

  // Next LFSR value: x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0
  assign lfsr_shift = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Never repeat the LED just shown: bump a colliding nibble by one (wraps 15->0)
  assign alvo = (lfsr_shift[3:0] == pos_q) ? pos_q + 4'd1 : lfsr_shift[3:0];

  // Next-state decode; round ends win over pause, and pause ignores round ends
  always_comb begin
    st_nxt = st;
    case (st)
      OCIOSO:      if (bus.iniciar) st_nxt = PREPARA;
      PREPARA:     st_nxt = NOVA_RODADA;
      NOVA_RODADA: st_nxt = JOGANDO;
      JOGANDO: begin
        if (round_end)       st_nxt = AVALIA;
        else if (bus.pausar) st_nxt = PAUSA;
      end
      PAUSA:       if (bus.pausar) st_nxt = JOGANDO;
      AVALIA: begin
        if (atingiu_meta || esgotou_rodadas) st_nxt = FIM;
        else                                 st_nxt = NOVA_RODADA;
      end
      FIM:         if (bus.iniciar) st_nxt = PREPARA;
      default:     st_nxt = OCIOSO;
    endcase
  end

  // State, target generator, match bookkeeping and registered strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= OCIOSO;
      lfsr        <= LFSR_SEED;
      pos_q       <= 4'd0;
      nivel_q     <= 2'd0;
      rodada_q    <= 8'd0;
      conta_q     <= 1'b0;
      rst_ponto_q <= 1'b0;
      rst_nivel_q <= 1'b0;
      fim_q       <= 1'b0;
      venceu_q    <= 1'b0;
    end else begin
      st <= st_nxt;

      // Strobes decoded from the next state so they are high exactly while in that state
      conta_q     <= (st_nxt == JOGANDO);
      rst_ponto_q <= (st_nxt == PREPARA);
      rst_nivel_q <= (st_nxt == PREPARA) || (st_nxt == NOVA_RODADA);
      fim_q       <= (st_nxt == FIM);

      if (start_req) begin
        nivel_q  <= bus.nivel_sel;
        rodada_q <= 8'd0;
        venceu_q <= 1'b0;
      end

      // The LFSR only moves here, so the target holds through play, pause and FIM
      if (st == NOVA_RODADA) begin
        lfsr  <= lfsr_shift;
        pos_q <= alvo;
        if (rodada_q != 8'hFF) rodada_q <= rodada_q + 8'd1;
      end

      // Score is sampled one cycle after the round end so the datapath update is visible
      if (st == AVALIA && st_nxt == FIM) venceu_q <= atingiu_meta;
    end
  end

  assign bus.estado            = st;
  assign bus.conta_nivel       = conta_q;
  assign bus.reset_ponto       = rst_ponto_q;
  assign bus.reset_nivel       = rst_nivel_q;
  assign bus.position_led      = pos_q;
  assign bus.nivel_dificuldade = nivel_q;
  assign bus.rodada            = rodada_q;
  assign bus.fim_jogo          = fim_q;
  assign bus.venceu            = venceu_q;

endmodule

// File: tb/tb_jogo_sequenciador.sv
// Directed bench for jogo_sequenciador. Main instance uses META_PONTOS=2 and
// MAX_RODADAS=3; a second instance with seed 8'h18 yields a first nibble equal
// to the reset target (0), exercising the +1 collision rule.
module tb_jogo_sequenciador;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  jogo_sequenciador_if ifa ();
  jogo_sequenciador_if ifb ();

  jogo_sequenciador #(.META_PONTOS(2), .MAX_RODADAS(3), .LFSR_SEED(8'hA5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifa.slave)
  );

  jogo_sequenciador #(.META_PONTOS(10), .MAX_RODADAS(20), .LFSR_SEED(8'h18)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (ifb.slave)
  );

  always #5 clock = ~clock;

  // One rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".estado"},  32'(ifa.estado), 32'd0);
    check({tag, ".conta"},   32'(ifa.conta_nivel), 32'd0);
    check({tag, ".rponto"},  32'(ifa.reset_ponto), 32'd0);
    check({tag, ".rnivel"},  32'(ifa.reset_nivel), 32'd0);
    check({tag, ".pos"},     32'(ifa.position_led), 32'd0);
    check({tag, ".nivel"},   32'(ifa.nivel_dificuldade), 32'd0);
    check({tag, ".rodada"},  32'(ifa.rodada), 32'd0);
    check({tag, ".fim"},     32'(ifa.fim_jogo), 32'd0);
    check({tag, ".venceu"},  32'(ifa.venceu), 32'd0);
  endtask

  // Start sequence from idle: PREPARA, NOVA_RODADA, JOGANDO with first target 4'hA
  task automatic start_seq(input string tag);
    ifa.nivel_sel = 2'd2;
    ifa.iniciar   = 1'b1;
    tick();
    ifa.iniciar   = 1'b0;
    check({tag, ".s1"},      32'(ifa.estado), 32'd1);
    check({tag, ".rp1"},     32'(ifa.reset_ponto), 32'd1);
    check({tag, ".rn1"},     32'(ifa.reset_nivel), 32'd1);
    check({tag, ".nivel"},   32'(ifa.nivel_dificuldade), 32'd2);
    check({tag, ".rod0"},    32'(ifa.rodada), 32'd0);
    tick();
    check({tag, ".s2"},      32'(ifa.estado), 32'd2);
    check({tag, ".rp2"},     32'(ifa.reset_ponto), 32'd0);
    check({tag, ".rn2"},     32'(ifa.reset_nivel), 32'd1);
    tick();
    check({tag, ".s3"},      32'(ifa.estado), 32'd3);
    check({tag, ".conta"},   32'(ifa.conta_nivel), 32'd1);
    check({tag, ".rn3"},     32'(ifa.reset_nivel), 32'd0);
    check({tag, ".rod1"},    32'(ifa.rodada), 32'd1);
    check({tag, ".pos"},     32'(ifa.position_led), 32'hA);
  endtask

  initial begin
    ifa.iniciar = 0; ifa.pausar = 0; ifa.nivel_sel = 0;
    ifa.ganhou_ponto = 0; ifa.perdeu_ponto = 0; ifa.pontuacao = 0;
    ifb.iniciar = 0; ifb.pausar = 0; ifb.nivel_sel = 0;
    ifb.ganhou_ponto = 0; ifb.perdeu_ponto = 0; ifb.pontuacao = 0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_idle("rst");

    // First match start; second instance started alongside
    ifb.iniciar = 1'b1;
    fork
      start_seq("start");
      begin tick(); ifb.iniciar = 1'b0; end
    join
    check("dut2.estado", 32'(ifb.estado), 32'd3);
    check("dut2.collide", 32'(ifb.position_led), 32'd1);

    // Pause, ignored round end while paused, resume
    ifa.pausar = 1'b1;
    tick();
    ifa.pausar = 1'b0;
    check("pause.estado", 32'(ifa.estado), 32'd4);
    check("pause.conta",  32'(ifa.conta_nivel), 32'd0);
    ifa.ganhou_ponto = 1'b1;
    tick();
    ifa.ganhou_ponto = 1'b0;
    check("pause.ignore", 32'(ifa.estado), 32'd4);
    tick();
    check("pause.hold",   32'(ifa.estado), 32'd4);
    ifa.pausar = 1'b1;
    tick();
    ifa.pausar = 1'b0;
    check("resume.estado", 32'(ifa.estado), 32'd3);
    check("resume.conta",  32'(ifa.conta_nivel), 32'd1);

    // iniciar during play is ignored
    ifa.iniciar = 1'b1;
    tick();
    ifa.iniciar = 1'b0;
    check("play.iniciar", 32'(ifa.estado), 32'd3);
    check("play.rodada",  32'(ifa.rodada), 32'd1);

    // Round 1 won, score becomes 1 -> next round (3-cycle turnaround)
    ifa.ganhou_ponto = 1'b1;
    tick();
    ifa.ganhou_ponto = 1'b0;
    ifa.pontuacao    = 8'd1;
    check("r1.avalia", 32'(ifa.estado), 32'd5);
    check("r1.conta",  32'(ifa.conta_nivel), 32'd0);
    tick();
    check("r1.nova",   32'(ifa.estado), 32'd2);
    check("r1.rn",     32'(ifa.reset_nivel), 32'd1);
    tick();
    check("r2.estado", 32'(ifa.estado), 32'd3);
    check("r2.conta",  32'(ifa.conta_nivel), 32'd1);
    check("r2.rodada", 32'(ifa.rodada), 32'd2);
    check("r2.pos",    32'(ifa.position_led), 32'h5);

    // Round 2 won, score reaches META_PONTOS=2 -> FIM with win
    ifa.ganhou_ponto = 1'b1;
    tick();
    ifa.ganhou_ponto = 1'b0;
    ifa.pontuacao    = 8'd2;
    check("win.avalia", 32'(ifa.estado), 32'd5);
    tick();
    check("win.estado", 32'(ifa.estado), 32'd6);
    check("win.fim",    32'(ifa.fim_jogo), 32'd1);
    check("win.venceu", 32'(ifa.venceu), 32'd1);
    check("win.rodada", 32'(ifa.rodada), 32'd2);
    tick();
    check("fim.hold",   32'(ifa.estado), 32'd6);
    check("fim.venceu", 32'(ifa.venceu), 32'd1);
    check("fim.pos",    32'(ifa.position_led), 32'h5);

    // Restart from FIM with new difficulty; LFSR continues (0x2A -> A)
    ifa.pontuacao = 8'd0;
    ifa.nivel_sel = 2'd1;
    ifa.iniciar   = 1'b1;
    tick();
    ifa.iniciar   = 1'b0;
    check("re.estado", 32'(ifa.estado), 32'd1);
    check("re.venceu", 32'(ifa.venceu), 32'd0);
    check("re.fim",    32'(ifa.fim_jogo), 32'd0);
    check("re.rodada", 32'(ifa.rodada), 32'd0);
    check("re.nivel",  32'(ifa.nivel_dificuldade), 32'd1);
    tick();
    tick();
    check("re.play",   32'(ifa.estado), 32'd3);
    check("re.rod1",   32'(ifa.rodada), 32'd1);
    check("re.pos",    32'(ifa.position_led), 32'hA);

    // Simultaneous win and lose pulses: one AVALIA, one increment (0x54 -> 4)
    ifa.ganhou_ponto = 1'b1;
    ifa.perdeu_ponto = 1'b1;
    tick();
    ifa.ganhou_ponto = 1'b0;
    ifa.perdeu_ponto = 1'b0;
    check("both.avalia", 32'(ifa.estado), 32'd5);
    tick();
    check("both.nova",   32'(ifa.estado), 32'd2);
    tick();
    check("both.play",   32'(ifa.estado), 32'd3);
    check("both.rodada", 32'(ifa.rodada), 32'd2);
    check("both.pos",    32'(ifa.position_led), 32'h4);

    // Losses until MAX_RODADAS=3 ends the match without a win (0xA9 -> 9)
    ifa.perdeu_ponto = 1'b1;
    tick();
    ifa.perdeu_ponto = 1'b0;
    tick();
    tick();
    check("lose.r3",     32'(ifa.rodada), 32'd3);
    check("lose.pos",    32'(ifa.position_led), 32'h9);
    ifa.perdeu_ponto = 1'b1;
    tick();
    ifa.perdeu_ponto = 1'b0;
    tick();
    check("lose.estado", 32'(ifa.estado), 32'd6);
    check("lose.fim",    32'(ifa.fim_jogo), 32'd1);
    check("lose.venceu", 32'(ifa.venceu), 32'd0);
    check("lose.rodada", 32'(ifa.rodada), 32'd3);

    // Restart, then reset mid-round while counting
    ifa.iniciar = 1'b1;
    tick();
    ifa.iniciar = 1'b0;
    tick();
    tick();
    check("mid.conta", 32'(ifa.conta_nivel), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("midrst");

    // Reset wins over iniciar in the same cycle
    reset = 1'b1;
    ifa.iniciar = 1'b1;
    tick();
    reset = 1'b0;
    ifa.iniciar = 1'b0;
    check("prio.estado", 32'(ifa.estado), 32'd0);

    // Replay of the start sequence from a fresh seed
    start_seq("replay");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
